hsv_core_writeback: RTL and testbench
=====================================

Name: hsv_core_writeback

Overview:
Commit/writeback end of the issue-to-execute interface. Accepts completed results from the four execution units (ALU, branch, control-status, memory) over valid/ready channels. Arbitrates round-robin and drives the issue stage regfile write port (wr_addr/wr_data/wr_en), one register write per cycle. Keeps a retired-instruction counter and joins the core flush handshake.

Parameters:
XLEN, 32, result/data width
REG_W, 5, register address width
CNT_W, 64, retired-instruction counter width (bench may reduce to test wrap)

Ports:
clk_core  in  1  core clock
rst_core_n  in  1  reset; asynchronous assert, active-low
flush_req  in  1  flush request from core control
flush_ack  out  1  flush acknowledge
<u>_valid_i  in  1  result valid, for u in {alu, branch, ctrl_status, mem}
<u>_ready_o  out  1  result accepted this cycle when high with <u>_valid_i
<u>_rd_addr  in  REG_W  destination register
<u>_result  in  XLEN  result value
<u>_write_rd  in  1  instruction writes rd (0 for stores, most branches)
wr_addr  out  REG_W  regfile write address
wr_data  out  XLEN  regfile write data
wr_en  out  1  regfile write enable
retire_o  out  1  one-cycle pulse per retired instruction
retired_count  out  CNT_W  total retired instructions

Behaviour:
- Reset (async, rst_core_n=0): wr_en=0, wr_addr=0, wr_data=0, retire_o=0, retired_count=0, flush_ack=0, rr pointer last=3 (mem). ALU has top priority on the first arbitration after reset.
- Unit index: alu=0, branch=1, ctrl_status=2, mem=3.
- Arbitration (combinational):
  - Search valid inputs starting at (last+1) mod 4, wrapping. The first valid input found is granted.
  - Only the granted input sees <u>_ready_o=1; all other ready_o are 0.
  - Ready is 0 for every input while flush_req=1.
- Acceptance: <u>_valid_i & <u>_ready_o. At most one acceptance per cycle. On acceptance, last <= granted index; otherwise last holds.
- Source rule: a unit holds valid and its payload stable until accepted. Ready may depend on the other inputs' valid; the bench must not require ready before valid.
- Output register, latency 1 cycle from acceptance:
  - wr_en <= write_rd & (rd_addr != 0). A write to x0 is never issued.
  - wr_addr <= rd_addr; wr_data <= result, updated on every acceptance.
  - retire_o <= 1, including when wr_en=0.
  - retired_count <= retired_count + 1, modulo 2^CNT_W (wraps silently).
- No acceptance in a cycle: wr_en <= 0 and retire_o <= 0 next cycle. wr_addr and wr_data hold.
- Back-to-back: a new acceptance every cycle is allowed. wr_en may stay high on consecutive cycles.
- Flush:
  - flush_ack <= flush_req, registered, so ack follows req by one cycle.
  - While flush_req=1: no acceptance, so wr_en=0 and retire_o=0 from the next cycle.
  - A result accepted in the cycle before flush_req rises still writes, one cycle later. Writeback is past the point of no return.
  - retired_count is not cleared by flush.
  - The rr pointer holds during flush.
- Simultaneous flush_req and valids: flush wins; nothing is accepted.
- Reset mid-operation: all outputs drop to reset values immediately (async). Any in-flight accepted result is lost.
- No buffering beyond the single output register; no backpressure exists from the regfile.

Test Plan:
- Single ALU result: alu_valid_i=1, rd=5, result=0xDEADBEEF, write_rd=1 -> alu_ready_o=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, retire_o=1, retired_count=1.
- All four valid out of reset, held until accepted, rd=1..4 -> grants alu, branch, ctrl_status, mem on 4 consecutive cycles; wr_en high 4 cycles, wr_addr 1,2,3,4; retired_count=4.
- Fairness: alu and mem both permanently valid after a mem grant -> grants alternate alu, mem, alu, mem; neither starves.
- x0 and no-write: branch rd=0 write_rd=1, then mem write_rd=0 rd=7 -> wr_en=0 both cycles; retire_o=1 both; retired_count +2.
- Flush mid-stream: alu valid continuously, flush_req high 3 cycles -> ready_o=0 and no retire for those cycles. flush_ack high cycles 2-4 relative to req start. The write accepted the cycle before flush still appears.
- Reset mid-op and wrap: CNT_W=4, retire 17 instructions -> retired_count=1. Assert rst_core_n=0 mid-burst -> wr_en=0 and retired_count=0 immediately; after release, ALU is granted first.

Source files
------------

// File: rtl/hsv_core_writeback_if.sv
// Result channels from the four execution units into the writeback stage.
// The master side is the execution unit; the slave side is writeback.
interface hsv_core_writeback_if #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
);
    logic             alu_valid_i;
    logic             alu_ready_o;
    logic [REG_W-1:0] alu_rd_addr;
    logic [XLEN-1:0]  alu_result;
    logic             alu_write_rd;

    logic             branch_valid_i;
    logic             branch_ready_o;
    logic [REG_W-1:0] branch_rd_addr;
    logic [XLEN-1:0]  branch_result;
    logic             branch_write_rd;

    logic             ctrl_status_valid_i;
    logic             ctrl_status_ready_o;
    logic [REG_W-1:0] ctrl_status_rd_addr;
    logic [XLEN-1:0]  ctrl_status_result;
    logic             ctrl_status_write_rd;

    logic             mem_valid_i;
    logic             mem_ready_o;
    logic [REG_W-1:0] mem_rd_addr;
    logic [XLEN-1:0]  mem_result;
    logic             mem_write_rd;

    modport master (
        output alu_valid_i, alu_rd_addr, alu_result, alu_write_rd,
        output branch_valid_i, branch_rd_addr, branch_result, branch_write_rd,
        output ctrl_status_valid_i, ctrl_status_rd_addr, ctrl_status_result, ctrl_status_write_rd,
        output mem_valid_i, mem_rd_addr, mem_result, mem_write_rd,
        input  alu_ready_o, branch_ready_o, ctrl_status_ready_o, mem_ready_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_addr, alu_result, alu_write_rd,
        input  branch_valid_i, branch_rd_addr, branch_result, branch_write_rd,
        input  ctrl_status_valid_i, ctrl_status_rd_addr, ctrl_status_result, ctrl_status_write_rd,
        input  mem_valid_i, mem_rd_addr, mem_result, mem_write_rd,
        output alu_ready_o, branch_ready_o, ctrl_status_ready_o, mem_ready_o
    );
endinterface

// File: rtl/hsv_core_writeback.sv
// Writeback stage: round-robin arbitration of execution-unit results onto the
// single regfile write port, with retire counting and flush acknowledge.
module hsv_core_writeback #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5,
    parameter int CNT_W = 64
) (
    input  logic                 clk_core,
    input  logic                 rst_core_n,
    input  logic                 flush_req,
    output logic                 flush_ack,
    hsv_core_writeback_if.slave  res,
    output logic [REG_W-1:0]     wr_addr,
    output logic [XLEN-1:0]      wr_data,
    output logic                 wr_en,
    output logic                 retire_o,
    output logic [CNT_W-1:0]     retired_count
);
    logic [1:0]       r_last;
    logic             r_wr_en;
    logic [REG_W-1:0] r_wr_addr;
    logic [XLEN-1:0]  r_wr_data;
    logic             r_retire;
    logic [CNT_W-1:0] r_count;
    logic             r_flush_ack;

    logic [3:0]       w_valid;
    logic [1:0]       w_cand;
    logic [1:0]       w_grant_idx;
    logic             w_grant_vld;
    logic             w_accept;
    logic [REG_W-1:0] w_sel_rd;
    logic [XLEN-1:0]  w_sel_result;
    logic             w_sel_write_rd;

    assign w_valid = {res.mem_valid_i, res.ctrl_status_valid_i,
                      res.branch_valid_i, res.alu_valid_i};

    // Round-robin search; walking offsets high to low lets the nearest valid unit win.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = r_last;
        w_cand      = r_last;
        for (int i = 4; i >= 1; i--) begin
            w_cand      = r_last + 2'(i);
            w_grant_vld = w_grant_vld | w_valid[w_cand];
            w_grant_idx = w_valid[w_cand] ? w_cand : w_grant_idx;
        end
        w_accept = w_grant_vld & ~flush_req;
    end

    // Payload select for the granted unit.
    always_comb begin
        w_sel_rd       = res.alu_rd_addr;
        w_sel_result   = res.alu_result;
        w_sel_write_rd = res.alu_write_rd;
        case (w_grant_idx)
            2'd0: begin
                w_sel_rd       = res.alu_rd_addr;
                w_sel_result   = res.alu_result;
                w_sel_write_rd = res.alu_write_rd;
            end
            2'd1: begin
                w_sel_rd       = res.branch_rd_addr;
                w_sel_result   = res.branch_result;
                w_sel_write_rd = res.branch_write_rd;
            end
            2'd2: begin
                w_sel_rd       = res.ctrl_status_rd_addr;
                w_sel_result   = res.ctrl_status_result;
                w_sel_write_rd = res.ctrl_status_write_rd;
            end
            2'd3: begin
                w_sel_rd       = res.mem_rd_addr;
                w_sel_result   = res.mem_result;
                w_sel_write_rd = res.mem_write_rd;
            end
            default: begin
                w_sel_rd       = res.alu_rd_addr;
                w_sel_result   = res.alu_result;
                w_sel_write_rd = res.alu_write_rd;
            end
        endcase
    end

    assign res.alu_ready_o         = w_accept & (w_grant_idx == 2'd0);
    assign res.branch_ready_o      = w_accept & (w_grant_idx == 2'd1);
    assign res.ctrl_status_ready_o = w_accept & (w_grant_idx == 2'd2);
    assign res.mem_ready_o         = w_accept & (w_grant_idx == 2'd3);

    // Output register; x0 writes retire but never assert the write enable.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_last      <= 2'd3;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_retire    <= 1'b0;
            r_count     <= '0;
            r_flush_ack <= 1'b0;
        end else begin
            r_flush_ack <= flush_req;
            if (w_accept) begin
                r_last    <= w_grant_idx;
                r_wr_en   <= w_sel_write_rd & (w_sel_rd != '0);
                r_wr_addr <= w_sel_rd;
                r_wr_data <= w_sel_result;
                r_retire  <= 1'b1;
                r_count   <= r_count + CNT_W'(1);
            end else begin
                r_wr_en   <= 1'b0;
                r_retire  <= 1'b0;
            end
        end
    end

    assign wr_en         = r_wr_en;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign retire_o      = r_retire;
    assign retired_count = r_count;
    assign flush_ack     = r_flush_ack;
endmodule

// File: tb/tb_hsv_core_writeback.sv
// Bench for hsv_core_writeback: directed vector table, reset/wrap sequence,
// then random traffic against a behavioural round-robin model.
module tb_hsv_core_writeback;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk_core   = 1'b0;
    logic             rst_core_n = 1'b0;
    logic             flush_req  = 1'b0;
    logic             flush_ack;
    logic [REG_W-1:0] wr_addr;
    logic [XLEN-1:0]  wr_data;
    logic             wr_en;
    logic             retire_o;
    logic [CNT_W-1:0] retired_count;

    hsv_core_writeback_if #(.XLEN(XLEN), .REG_W(REG_W)) bus ();

    hsv_core_writeback #(.XLEN(XLEN), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_core      (clk_core),
        .rst_core_n    (rst_core_n),
        .flush_req     (flush_req),
        .flush_ack     (flush_ack),
        .res           (bus),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .retire_o      (retire_o),
        .retired_count (retired_count)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic [3:0]            valid;
        logic                  flush;
        logic [3:0][REG_W-1:0] rd;
        logic [3:0]            wrd;
        logic [3:0][XLEN-1:0]  res;
        logic [3:0]            e_ready;
        logic                  e_en;
        logic [REG_W-1:0]      e_addr;
        logic [XLEN-1:0]       e_data;
        logic                  e_ret;
        logic [CNT_W-1:0]      e_cnt;
        logic                  e_ack;
    } vec_t;

    vec_t tbl [18];

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]            v;
    logic                  fl;
    logic [3:0][REG_W-1:0] rd;
    logic [3:0][XLEN-1:0]  rs;
    logic [3:0]            wrd;
    logic [3:0]            obs_ready;

    int               m_last;
    int               m_count;
    int               m_grant;
    logic             m_en, m_ret, m_ack;
    logic [REG_W-1:0] m_addr;
    logic [XLEN-1:0]  m_data;

    function automatic vec_t mk(input logic [3:0] valid, input logic flush,
                                input logic [3:0][REG_W-1:0] r, input logic [3:0] w,
                                input logic [3:0][XLEN-1:0] d, input logic [3:0] er,
                                input logic ee, input logic [REG_W-1:0] ea,
                                input logic [XLEN-1:0] ed, input logic eret,
                                input logic [CNT_W-1:0] ec, input logic eack);
        vec_t t;
        t.valid = valid; t.flush = flush; t.rd = r; t.wrd = w; t.res = d;
        t.e_ready = er; t.e_en = ee; t.e_addr = ea; t.e_data = ed;
        t.e_ret = eret; t.e_cnt = ec; t.e_ack = eack;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.alu_valid_i          = v[0];
        bus.alu_rd_addr          = rd[0];
        bus.alu_result           = rs[0];
        bus.alu_write_rd         = wrd[0];
        bus.branch_valid_i       = v[1];
        bus.branch_rd_addr       = rd[1];
        bus.branch_result        = rs[1];
        bus.branch_write_rd      = wrd[1];
        bus.ctrl_status_valid_i  = v[2];
        bus.ctrl_status_rd_addr  = rd[2];
        bus.ctrl_status_result   = rs[2];
        bus.ctrl_status_write_rd = wrd[2];
        bus.mem_valid_i          = v[3];
        bus.mem_rd_addr          = rd[3];
        bus.mem_result           = rs[3];
        bus.mem_write_rd         = wrd[3];
        flush_req                = fl;
    endtask

    task automatic model_reset();
        m_last = 3; m_count = 0; m_en = 1'b0; m_ret = 1'b0; m_ack = 1'b0;
        m_addr = '0; m_data = '0;
    endtask

    // One clock: apply inputs at negedge, check ready, then check registered outputs.
    task automatic tick();
        drive();
        #1;
        obs_ready = {bus.mem_ready_o, bus.ctrl_status_ready_o, bus.branch_ready_o, bus.alu_ready_o};
        m_grant = -1;
        if (!fl) begin
            for (int k = 1; k <= 4; k++) begin
                int u;
                u = (m_last + k) % 4;
                if (v[u] && m_grant < 0) m_grant = u;
            end
        end
        check("ready", 64'(obs_ready), (m_grant < 0) ? 64'd0 : (64'd1 << m_grant));
        @(posedge clk_core);
        #1;
        if (m_grant >= 0) begin
            m_en    = wrd[m_grant] && (rd[m_grant] != '0);
            m_addr  = rd[m_grant];
            m_data  = rs[m_grant];
            m_ret   = 1'b1;
            m_count = (m_count + 1) % 16;
            m_last  = m_grant;
            v[m_grant] = 1'b0;
        end else begin
            m_en  = 1'b0;
            m_ret = 1'b0;
        end
        m_ack = fl;
        check("wr_en", 64'(wr_en), 64'(m_en));
        check("wr_addr", 64'(wr_addr), 64'(m_addr));
        check("wr_data", 64'(wr_data), 64'(m_data));
        check("retire", 64'(retire_o), 64'(m_ret));
        check("count", 64'(retired_count), 64'(m_count));
        check("flush_ack", 64'(flush_ack), 64'(m_ack));
        @(negedge clk_core);
    endtask

    initial begin
        tbl[0]  = mk(4'b1111, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1111,
                     {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                     4'b0001, 1'b1, 5'd1, 32'h1111_1111, 1'b1, 4'd1, 1'b0);
        tbl[1]  = mk(4'b1110, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1111,
                     {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                     4'b0010, 1'b1, 5'd2, 32'h2222_2222, 1'b1, 4'd2, 1'b0);
        tbl[2]  = mk(4'b1100, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1111,
                     {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                     4'b0100, 1'b1, 5'd3, 32'h3333_3333, 1'b1, 4'd3, 1'b0);
        tbl[3]  = mk(4'b1000, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1111,
                     {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                     4'b1000, 1'b1, 5'd4, 32'h4444_4444, 1'b1, 4'd4, 1'b0);
        tbl[4]  = mk(4'b0001, 1'b0, {5'd0, 5'd0, 5'd0, 5'd5}, 4'b0001,
                     {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF},
                     4'b0001, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 4'd5, 1'b0);
        tbl[5]  = mk(4'b0000, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000,
                     {32'h0, 32'h0, 32'h0, 32'h0},
                     4'b0000, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, 4'd5, 1'b0);
        tbl[6]  = mk(4'b1000, 1'b0, {5'd6, 5'd0, 5'd0, 5'd0}, 4'b1000,
                     {32'h6666_6666, 32'h0, 32'h0, 32'h0},
                     4'b1000, 1'b1, 5'd6, 32'h6666_6666, 1'b1, 4'd6, 1'b0);
        tbl[7]  = mk(4'b1001, 1'b0, {5'd6, 5'd0, 5'd0, 5'd7}, 4'b1001,
                     {32'h6666_6666, 32'h0, 32'h0, 32'h7777_7777},
                     4'b0001, 1'b1, 5'd7, 32'h7777_7777, 1'b1, 4'd7, 1'b0);
        tbl[8]  = mk(4'b1001, 1'b0, {5'd6, 5'd0, 5'd0, 5'd9}, 4'b1001,
                     {32'h6666_6666, 32'h0, 32'h0, 32'h9999_9999},
                     4'b1000, 1'b1, 5'd6, 32'h6666_6666, 1'b1, 4'd8, 1'b0);
        tbl[9]  = mk(4'b1001, 1'b0, {5'd8, 5'd0, 5'd0, 5'd9}, 4'b1001,
                     {32'h8888_8888, 32'h0, 32'h0, 32'h9999_9999},
                     4'b0001, 1'b1, 5'd9, 32'h9999_9999, 1'b1, 4'd9, 1'b0);
        tbl[10] = mk(4'b1000, 1'b0, {5'd8, 5'd0, 5'd0, 5'd0}, 4'b1000,
                     {32'h8888_8888, 32'h0, 32'h0, 32'h0},
                     4'b1000, 1'b1, 5'd8, 32'h8888_8888, 1'b1, 4'd10, 1'b0);
        tbl[11] = mk(4'b0010, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0010,
                     {32'h0, 32'h0, 32'hBBBB_BBBB, 32'h0},
                     4'b0010, 1'b0, 5'd0, 32'hBBBB_BBBB, 1'b1, 4'd11, 1'b0);
        tbl[12] = mk(4'b1000, 1'b0, {5'd7, 5'd0, 5'd0, 5'd0}, 4'b0000,
                     {32'hCCCC_CCCC, 32'h0, 32'h0, 32'h0},
                     4'b1000, 1'b0, 5'd7, 32'hCCCC_CCCC, 1'b1, 4'd12, 1'b0);
        tbl[13] = mk(4'b0001, 1'b0, {5'd0, 5'd0, 5'd0, 5'd3}, 4'b0001,
                     {32'h0, 32'h0, 32'h0, 32'hD1D1_D1D1},
                     4'b0001, 1'b1, 5'd3, 32'hD1D1_D1D1, 1'b1, 4'd13, 1'b0);
        for (int i = 14; i <= 16; i++) begin
            tbl[i] = mk(4'b0001, 1'b1, {5'd0, 5'd0, 5'd0, 5'd4}, 4'b0001,
                        {32'h0, 32'h0, 32'h0, 32'hD2D2_D2D2},
                        4'b0000, 1'b0, 5'd3, 32'hD1D1_D1D1, 1'b0, 4'd13, 1'b1);
        end
        tbl[17] = mk(4'b0001, 1'b0, {5'd0, 5'd0, 5'd0, 5'd4}, 4'b0001,
                     {32'h0, 32'h0, 32'h0, 32'hD2D2_D2D2},
                     4'b0001, 1'b1, 5'd4, 32'hD2D2_D2D2, 1'b1, 4'd14, 1'b0);

        v = '0; fl = 1'b0; rd = '0; rs = '0; wrd = '0;
        model_reset();
        drive();
        @(negedge clk_core);
        @(negedge clk_core);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_retire", 64'(retire_o), 64'd0);
        check("rst_count", 64'(retired_count), 64'd0);
        check("rst_flush_ack", 64'(flush_ack), 64'd0);
        rst_core_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            v = tbl[i].valid; fl = tbl[i].flush; rd = tbl[i].rd;
            wrd = tbl[i].wrd; rs = tbl[i].res;
            tick();
            check($sformatf("tbl%0d_ready", i), 64'(obs_ready), 64'(tbl[i].e_ready));
            check($sformatf("tbl%0d_wr_en", i), 64'(wr_en), 64'(tbl[i].e_en));
            check($sformatf("tbl%0d_wr_addr", i), 64'(wr_addr), 64'(tbl[i].e_addr));
            check($sformatf("tbl%0d_wr_data", i), 64'(wr_data), 64'(tbl[i].e_data));
            check($sformatf("tbl%0d_retire", i), 64'(retire_o), 64'(tbl[i].e_ret));
            check($sformatf("tbl%0d_count", i), 64'(retired_count), 64'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_ack", i), 64'(flush_ack), 64'(tbl[i].e_ack));
        end

        // Reset in the middle of a burst, then ALU first and counter wrap.
        v = 4'b0011; fl = 1'b0; rd = {5'd0, 5'd0, 5'd12, 5'd11}; wrd = 4'b0011;
        rs = {32'h0, 32'h0, 32'hB0B0_B0B0, 32'hA0A0_A0A0};
        tick();
        drive();
        #2;
        rst_core_n = 1'b0;
        #1;
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_count", 64'(retired_count), 64'd0);
        check("midrst_retire", 64'(retire_o), 64'd0);
        check("midrst_wr_addr", 64'(wr_addr), 64'd0);
        model_reset();
        v = '0;
        drive();
        @(negedge clk_core);
        rst_core_n = 1'b1;
        v = 4'b0011;
        tick();
        check("post_rst_alu_first", 64'(obs_ready), 64'd1);
        for (int i = 0; i < 16; i++) begin
            if (!v[0]) begin
                v[0]  = 1'b1;
                rd[0] = 5'($urandom_range(31, 0));
                rs[0] = $urandom;
            end
            tick();
        end
        check("wrap_count", 64'(retired_count), 64'd1);

        for (int n = 0; n < 400; n++) begin
            for (int u = 0; u < 4; u++) begin
                if (!v[u] && ($urandom_range(1, 0) == 1)) begin
                    v[u]   = 1'b1;
                    rd[u]  = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
                    rs[u]  = $urandom;
                    wrd[u] = 1'($urandom_range(1, 0));
                end
            end
            fl = ($urandom_range(7, 0) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
